// File: rtl/fec_ctrl_if.sv
// Handshake and config bundle between the burst scheduler, the FEC chain and fec_ctrl.
// The master side is the scheduler/FEC pair; fec_ctrl connects as slave.
interface fec_ctrl_if #(
  parameter int w  = 1,
  parameter int LW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic [LW-1:0] cmd_out_len;
  logic          cmd_rs;
  logic [1:0]    cmd_rate;
  logic [w-1:0]  src_bits;
  logic          src_valid;
  logic          src_ready;
  logic [w-1:0]  fec_in_bits;
  logic          fec_in_valid;
  logic          fec_out_valid;
  logic          enable_rs;
  logic [1:0]    cc_rate;
  logic          busy;
  logic          burst_done;
  logic          burst_err;

  modport master (
    output cmd_valid, cmd_len, cmd_out_len, cmd_rs, cmd_rate,
    output src_bits, src_valid, fec_out_valid,
    input  cmd_ready, src_ready, fec_in_bits, fec_in_valid,
    input  enable_rs, cc_rate, busy, burst_done, burst_err
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_out_len, cmd_rs, cmd_rate,
    input  src_bits, src_valid, fec_out_valid,
    output cmd_ready, src_ready, fec_in_bits, fec_in_valid,
    output enable_rs, cc_rate, busy, burst_done, burst_err
  );
endinterface

// File: rtl/fec_ctrl.sv
// Burst sequencer for the FEC chain: gates payload, appends a zero flush tail,
// then waits for the expected FEC output count or an idle timeout.
//
// state   | meaning
// S_IDLE  | waiting for a burst descriptor
// S_SETUP | one cycle: drive latched config onto the FEC pins
// S_DATA  | forwarding payload words
// S_TAIL  | emitting TAIL zero words to flush the encoder
// S_DRAIN | counting FEC output until expected length or timeout
// S_DONE  | one-cycle completion pulse
module fec_ctrl #(
  parameter int w       = 1,
  parameter int LW      = 16,
  parameter int TAIL    = 8,
  parameter int TIMEOUT = 1024
) (
  input logic     clk,
  input logic     reset,
  fec_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_DATA, S_TAIL, S_DRAIN, S_DONE
  } state_t;

  localparam logic [LW-1:0] ONE       = LW'(1);
  localparam logic [LW-1:0] TAIL_LAST = LW'(TAIL - 1);
  localparam logic [LW-1:0] IDLE_LAST = LW'(TIMEOUT - 1);

  state_t        state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] out_len_q;
  logic          rs_q;
  logic [1:0]    rate_q;
  logic [LW-1:0] in_cnt;
  logic [LW-1:0] out_cnt;
  logic [LW-1:0] tail_cnt;
  logic [LW-1:0] idle_cnt;
  logic          counting;

  // cmd_ready is masked during reset so the scheduler cannot hand off a descriptor into reset
  assign bus.cmd_ready = (state == S_IDLE) && !reset;
  assign bus.src_ready = (state == S_DATA);
  assign bus.busy      = (state != S_IDLE);
  assign counting      = (state == S_SETUP) || (state == S_DATA) ||
                         (state == S_TAIL)  || (state == S_DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      len_q            <= '0;
      out_len_q        <= '0;
      rs_q             <= 1'b0;
      rate_q           <= 2'd0;
      in_cnt           <= '0;
      out_cnt          <= '0;
      tail_cnt         <= '0;
      idle_cnt         <= '0;
      bus.fec_in_bits  <= '0;
      bus.fec_in_valid <= 1'b0;
      bus.enable_rs    <= 1'b0;
      bus.cc_rate      <= 2'd0;
      bus.burst_done   <= 1'b0;
      bus.burst_err    <= 1'b0;
    end else begin
      bus.burst_done   <= 1'b0;
      bus.fec_in_valid <= 1'b0;

      // FEC output can begin while payload or tail is still going in
      if (counting && bus.fec_out_valid && (out_cnt != '1))
        out_cnt <= out_cnt + ONE;

      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            len_q         <= bus.cmd_len;
            out_len_q     <= bus.cmd_out_len;
            rs_q          <= bus.cmd_rs;
            rate_q        <= bus.cmd_rate;
            in_cnt        <= '0;
            out_cnt       <= '0;
            tail_cnt      <= '0;
            idle_cnt      <= '0;
            bus.burst_err <= 1'b0;
            state         <= S_SETUP;
          end
        end
        S_SETUP: begin
          bus.enable_rs <= rs_q;
          bus.cc_rate   <= rate_q;
          state         <= (len_q != '0) ? S_DATA : S_TAIL;
        end
        S_DATA: begin
          if (bus.src_valid) begin
            bus.fec_in_bits  <= bus.src_bits;
            bus.fec_in_valid <= 1'b1;
            in_cnt           <= in_cnt + ONE;
            if ((in_cnt + ONE) == len_q)
              state <= S_TAIL;
          end
        end
        S_TAIL: begin
          bus.fec_in_bits  <= '0;
          bus.fec_in_valid <= 1'b1;
          tail_cnt         <= tail_cnt + ONE;
          if (tail_cnt == TAIL_LAST)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_cnt >= out_len_q) begin
            bus.burst_done <= 1'b1;
            state          <= S_DONE;
          end else if (bus.fec_out_valid) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            bus.burst_done <= 1'b1;
            bus.burst_err  <= 1'b1;
            state          <= S_DONE;
          end else begin
            idle_cnt <= idle_cnt + ONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
